aes_key_schedule: RTL

//  Iterative AES-128 key expansion, the stage upstream of encrypt_round. Takes one
//  128-bit cipher key and emits round keys 0..10 in order, one per accepted beat.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_sbox.sv | 9 +
 rtl/key_expand_step.sv | 18 +
 rtl/aes_key_schedule.sv | 74 +++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM encoding and the S-box byte function.
package aes_pkg;
   localparam int AES_NUM_ROUNDS = 10;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EMIT = 2'd1;
   localparam logic [1:0] ST_FIN = 2'd2;
   typedef enum logic [1:0] {IDLE = ST_IDLE, EMIT = ST_EMIT, FIN = ST_FIN} fsmState;
   // Padded to 16 entries so a 4-bit round index addresses it directly.
   localparam logic [0:15][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 48'h0};
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p ^= b[i] ? x : 8'h00;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction
   // Multiplicative inverse as a^254 (0 maps to 0), then the FIPS-197 affine map.
   function automatic logic [7:0] subByte(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gfMul(sq, sq);
         inv = gfMul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES SubBytes lookup for one byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] inByte,
   output logic [7:0] outByte
);
   assign outByte = subByte(inByte);
endmodule

// File: rtl/key_expand_step.sv
// key_expand_step: one AES-128 key-expansion step from round key N to round key N+1.
module key_expand_step (
   input  logic [127:0] in_key,
   input  logic [7:0]   rcon,
   output logic [127:0] out_key
);
   logic [31:0] rotW3, subW3, t, w0, w1, w2, w3;
   assign rotW3 = {in_key[23:0], in_key[31:24]};
   for (genvar i = 0; i < 4; i++) begin : gSbox
      aes_sbox uSbox (.inByte(rotW3[8*i +: 8]), .outByte(subW3[8*i +: 8]));
   end
   assign t = subW3 ^ {rcon, 24'h0};
   assign w0 = in_key[127:96] ^ t;
   assign w1 = in_key[95:64] ^ w0;
   assign w2 = in_key[63:32] ^ w1;
   assign w3 = in_key[31:0] ^ w2;
   assign out_key = {w0, w1, w2, w3};
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion streaming round keys 0..10
// over a valid/ready handshake; only the current round key is stored.
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_index,
   output logic         done
);
   fsmState state, nextState;
   logic [127:0] expanded, nextData;
   logic [3:0] nextIndex;
   logic nextValid, nextBusy, nextDone, lastKey;
   key_expand_step uStep (.in_key(rk_data), .rcon(RCON[rk_index]), .out_key(expanded));
   assign lastKey = rk_index == 4'(NUM_ROUNDS);
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         rk_data <= '0;
         rk_index <= '0;
         rk_valid <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= nextState;
         rk_data <= nextData;
         rk_index <= nextIndex;
         rk_valid <= nextValid;
         busy <= nextBusy;
         done <= nextDone;
      end
   end
   always_comb begin
      nextState = state;
      nextData = rk_data;
      nextIndex = rk_index;
      nextValid = rk_valid;
      nextBusy = busy;
      nextDone = 1'b0;
      case (state)
         IDLE: if (start) begin
            nextData = key_in;
            nextIndex = '0;
            nextValid = 1'b1;
            nextBusy = 1'b1;
            nextState = EMIT;
         end
         EMIT: if (rk_valid && rk_ready) begin
            if (!lastKey) begin
               nextData = expanded;
               nextIndex = rk_index + 4'd1;
            end else begin
               nextValid = 1'b0;
               nextDone = 1'b1;
               nextState = FIN;
            end
         end
         FIN: begin
            nextBusy = 1'b0;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end
endmodule
